// File: rtl/present_pkg.sv
// Shared types and constants for the PRESENT encrypt-core scheduler.
package present_pkg;

   localparam int BLK_W           = 64;
   localparam int KEY_W           = 80;
   localparam int CORE_ROUNDS     = 31;
   localparam int SCHED_LATENCY   = 33;
   localparam int TIMEOUT_CYC_DEF = 40;
   localparam int CNT_W           = 6;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      BUSY,
      RESP
   } state_t;

   // Saturating increment: the BUSY counter parks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/present_rr_arb2.sv
// Two-input round-robin arbiter with a last-grant pointer that moves only on accept.
module present_rr_arb2
   import present_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_valid0,
   input  logic i_valid1,
   input  logic i_accept,
   output logic o_grantId,
   output logic o_grantValid
);

   logic r_lastGrant;

   // On contention the requester that was not served last wins; otherwise the lone requester.
   always_comb begin
      o_grantValid = i_valid0 | i_valid1;
      if (i_valid0 && i_valid1) begin
         o_grantId = ~r_lastGrant;
      end else begin
         o_grantId = i_valid1;
      end
   end

   // Reset value 1 makes requester 0 the first winner.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lastGrant <= 1'b1;
      end else if (i_accept) begin
         r_lastGrant <= o_grantId;
      end
   end

endmodule

// File: rtl/present_enc_sched.sv
// Scheduler sharing one PRESENT-80 encrypt core between two requesters.
// Optional watchdog (adds rsp_err): define PRESENT_SCHED_WATCHDOG_EN.
module present_enc_sched
   import present_pkg::*;
#(
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic             req1_valid,
   output logic             req0_ready,
   output logic             req1_ready,
   input  logic [BLK_W-1:0] req0_pt,
   input  logic [BLK_W-1:0] req1_pt,
   input  logic [KEY_W-1:0] req0_key,
   input  logic [KEY_W-1:0] req1_key,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [BLK_W-1:0] rsp_ct,
   output logic             rsp_id,
   output logic             core_load,
   output logic [BLK_W-1:0] core_idat,
   output logic [KEY_W-1:0] core_key,
   input  logic [BLK_W-1:0] core_odat,
   input  logic             core_done,
`ifdef PRESENT_SCHED_WATCHDOG_EN
   output logic             rsp_err,
`endif
   output logic             busy
);

`ifdef PRESENT_SCHED_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] DONE_MIN = CNT_W'(CORE_ROUNDS);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

   state_t           r_state;
   logic [BLK_W-1:0] r_pt;
   logic [KEY_W-1:0] r_key;
   logic             r_id;
   logic [BLK_W-1:0] r_rspCt;
   logic             r_rspId;
   logic             r_rspValid;
   logic             r_coreLoad;
   logic             r_busy;
   logic [CNT_W-1:0] r_cnt;
`ifdef PRESENT_SCHED_WATCHDOG_EN
   logic             r_rspErr;
`endif

   logic w_grantId;
   logic w_grantValid;
   logic w_idle;
   logic w_accept;
   logic w_doneOk;
   logic w_timeout;

   present_rr_arb2 u_arb (
      .clk          (clk),
      .rst          (rst),
      .i_valid0     (req0_valid),
      .i_valid1     (req1_valid),
      .i_accept     (w_accept),
      .o_grantId    (w_grantId),
      .o_grantValid (w_grantValid)
   );

   assign w_idle     = (r_state == IDLE) && !rst;
   assign req0_ready = w_idle && w_grantValid && !w_grantId;
   assign req1_ready = w_idle && w_grantValid && w_grantId;
   assign w_accept   = (req0_ready && req0_valid) || (req1_ready && req1_valid);

   // The core has no reset, so done is only trusted once r_cnt shows 31 completed BUSY cycles.
   assign w_doneOk  = core_done && (r_cnt >= DONE_MIN);
   assign w_timeout = WD_EN && (r_cnt >= TO_LAST);

   assign core_idat = r_pt;
   assign core_key  = r_key;
   assign core_load = r_coreLoad;
   assign rsp_valid = r_rspValid;
   assign rsp_ct    = r_rspCt;
   assign rsp_id    = r_rspId;
   assign busy      = r_busy;
`ifdef PRESENT_SCHED_WATCHDOG_EN
   assign rsp_err   = r_rspErr;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= IDLE;
         r_pt       <= '0;
         r_key      <= '0;
         r_id       <= 1'b0;
         r_rspCt    <= '0;
         r_rspId    <= 1'b0;
         r_rspValid <= 1'b0;
         r_coreLoad <= 1'b0;
         r_busy     <= 1'b0;
         r_cnt      <= '0;
`ifdef PRESENT_SCHED_WATCHDOG_EN
         r_rspErr   <= 1'b0;
`endif
      end else begin
         r_coreLoad <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_pt       <= w_grantId ? req1_pt  : req0_pt;
                  r_key      <= w_grantId ? req1_key : req0_key;
                  r_id       <= w_grantId;
                  r_coreLoad <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= LOAD;
               end
            end
            LOAD: begin
               r_cnt   <= '0;
               r_state <= BUSY;
            end
            BUSY: begin
               r_cnt <= satInc(r_cnt);
               if (w_doneOk) begin
                  r_rspCt    <= core_odat;
                  r_rspId    <= r_id;
                  r_rspValid <= 1'b1;
`ifdef PRESENT_SCHED_WATCHDOG_EN
                  r_rspErr   <= 1'b0;
`endif
                  r_state    <= RESP;
               end else if (w_timeout) begin
                  r_rspCt    <= '0;
                  r_rspId    <= r_id;
                  r_rspValid <= 1'b1;
`ifdef PRESENT_SCHED_WATCHDOG_EN
                  r_rspErr   <= 1'b1;
`endif
                  r_state    <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_busy     <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_present_enc_sched.sv
// Directed testbench for present_enc_sched with a behavioural encrypt-core stand-in.
// Build with PRESENT_SCHED_WATCHDOG_EN defined to exercise the watchdog path.
module tb_present_enc_sched;

   localparam logic [63:0] P_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [79:0] K_ONES  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] CT_ZERO = 64'h5579_c138_7b22_8445;
   localparam logic [63:0] CT_ONES = 64'h3333_dcd3_2132_10d2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [63:0] req0_pt, req1_pt;
   logic [79:0] req0_key, req1_key;
   logic        rsp_valid, rsp_ready, rsp_id, core_load, core_done, busy;
   logic [63:0] rsp_ct, core_idat, core_odat;
   logic [79:0] core_key;
`ifdef PRESENT_SCHED_WATCHDOG_EN
   logic        rsp_err;
`endif

   int testsRun    = 0;
   int testsFailed = 0;

   // Core stand-in: stale done for 5 cycles after load, real result from its 31st cycle on.
   logic [5:0]  coreCyc    = 6'd0;
   logic        coreActive = 1'b0;
   logic [63:0] coreRes    = 64'd0;
   logic        coreDead   = 1'b0;

   always #5 clk = ~clk;

   present_enc_sched #(.TIMEOUT_CYC(40)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req1_valid (req1_valid),
      .req0_ready (req0_ready),
      .req1_ready (req1_ready),
      .req0_pt    (req0_pt),
      .req1_pt    (req1_pt),
      .req0_key   (req0_key),
      .req1_key   (req1_key),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_ct     (rsp_ct),
      .rsp_id     (rsp_id),
      .core_load  (core_load),
      .core_idat  (core_idat),
      .core_key   (core_key),
      .core_odat  (core_odat),
      .core_done  (core_done),
`ifdef PRESENT_SCHED_WATCHDOG_EN
      .rsp_err    (rsp_err),
`endif
      .busy       (busy)
   );

   function automatic logic [63:0] coreLookup(input logic [63:0] pt, input logic [79:0] key);
      if (pt == 64'd0 && key == 80'd0) return CT_ZERO;
      if (pt == P_ONES && key == K_ONES) return CT_ONES;
      return pt ^ 64'h0123_4567_89ab_cdef;
   endfunction

   always @(posedge clk) begin
      if (core_load) begin
         coreCyc    <= 6'd0;
         coreActive <= 1'b1;
         coreRes    <= coreLookup(core_idat, core_key);
      end else if (coreCyc != 6'd63) begin
         coreCyc <= coreCyc + 6'd1;
      end
   end

   assign core_done = !coreDead && ((coreCyc < 6'd5) || (coreActive && coreCyc >= 6'd30));
   assign core_odat = (coreActive && coreCyc >= 6'd30) ? coreRes : 64'hBADC_0DE0_BADC_0DE0;

   task automatic checkOutput(input string tag, input logic [79:0] got, input logic [79:0] exp);
      testsRun++;
      if (got !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic v0, input logic v1,
                                input logic [63:0] p0, input logic [79:0] k0,
                                input logic [63:0] p1, input logic [79:0] k1);
      req0_valid = v0;
      req1_valid = v1;
      req0_pt    = p0;
      req0_key   = k0;
      req1_pt    = p1;
      req1_key   = k1;
   endtask

   // Ticks until rsp_valid is seen (bounded); cycles counts edges, loads counts core_load samples.
   task automatic waitResp(output int cycles, output int loads);
      cycles = 0;
      loads  = 0;
      do begin
         tick();
         cycles++;
         if (core_load) loads++;
      end while (!rsp_valid && cycles < 80);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: got running expected finished");
      $fatal(1, "[TB] simulation time limit");
   end

   initial begin
      int cyc;
      int lds;
      int seen;

      rsp_ready = 1'b1;
      applyStimulus(1'b1, 1'b1, 64'd0, 80'd0, P_ONES, K_ONES);
      repeat (3) tick();
      checkOutput("rst_ready0",   80'(req0_ready), 80'd0);
      checkOutput("rst_ready1",   80'(req1_ready), 80'd0);
      checkOutput("rst_rspValid", 80'(rsp_valid),  80'd0);
      checkOutput("rst_coreLoad", 80'(core_load),  80'd0);
      checkOutput("rst_rspCt",    80'(rsp_ct),     80'd0);
      checkOutput("rst_rspId",    80'(rsp_id),     80'd0);
      checkOutput("rst_busy",     80'(busy),       80'd0);
      checkOutput("rst_coreIdat", 80'(core_idat),  80'd0);
      checkOutput("rst_coreKey",  core_key,        80'd0);
`ifdef PRESENT_SCHED_WATCHDOG_EN
      checkOutput("rst_rspErr",   80'(rsp_err),    80'd0);
`endif
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      rst = 1'b0;
      tick();

      // req0 alone, all-zero block.
      applyStimulus(1'b1, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      #1;
      checkOutput("t0_ready0", 80'(req0_ready), 80'd1);
      checkOutput("t0_ready1", 80'(req1_ready), 80'd0);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      checkOutput("t0_coreLoad", 80'(core_load), 80'd1);
      checkOutput("t0_busy",     80'(busy),      80'd1);
      checkOutput("t0_ready0_busy", 80'(req0_ready), 80'd0);
      waitResp(cyc, lds);
      checkOutput("t0_latency", 80'(cyc), 80'd33);
      checkOutput("t0_extraLoads", 80'(lds), 80'd0);
      checkOutput("t0_rspCt", 80'(rsp_ct), 80'(CT_ZERO));
      checkOutput("t0_rspId", 80'(rsp_id), 80'd0);
`ifdef PRESENT_SCHED_WATCHDOG_EN
      checkOutput("t0_rspErr", 80'(rsp_err), 80'd0);
`endif
      tick();
      checkOutput("t0_rspDone", 80'(rsp_valid), 80'd0);
      checkOutput("t0_idle",    80'(busy),      80'd0);

      // req1 alone, all-ones block.
      applyStimulus(1'b0, 1'b1, 64'd0, 80'd0, P_ONES, K_ONES);
      #1;
      checkOutput("t1_ready0", 80'(req0_ready), 80'd0);
      checkOutput("t1_ready1", 80'(req1_ready), 80'd1);
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      checkOutput("t1_coreIdat", 80'(core_idat), 80'(P_ONES));
      checkOutput("t1_coreKey",  core_key,       K_ONES);
      waitResp(cyc, lds);
      checkOutput("t1_latency", 80'(cyc), 80'd33);
      checkOutput("t1_rspCt", 80'(rsp_ct), 80'(CT_ONES));
      checkOutput("t1_rspId", 80'(rsp_id), 80'd1);
      tick();

      // Both requesters valid from reset: grants alternate starting with req0.
      rst = 1'b1;
      tick();
      applyStimulus(1'b1, 1'b1, 64'd0, 80'd0, P_ONES, K_ONES);
      rst = 1'b0;
      #1;
      checkOutput("t2_firstGrant0", 80'(req0_ready), 80'd1);
      checkOutput("t2_firstGrant1", 80'(req1_ready), 80'd0);
      for (int b = 0; b < 4; b++) begin
         waitResp(cyc, lds);
         checkOutput($sformatf("t2_rspValid%0d", b), 80'(rsp_valid), 80'd1);
         checkOutput($sformatf("t2_rspId%0d", b), 80'(rsp_id), 80'(b % 2));
         checkOutput($sformatf("t2_rspCt%0d", b), 80'(rsp_ct),
                     (b % 2 == 0) ? 80'(CT_ZERO) : 80'(CT_ONES));
         checkOutput($sformatf("t2_loads%0d", b), 80'(lds), 80'd1);
      end
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      tick();

      // Response back-pressure: everything holds while rsp_ready is low.
      rsp_ready = 1'b0;
      applyStimulus(1'b1, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      #1;
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      waitResp(cyc, lds);
      checkOutput("t3_latency", 80'(cyc), 80'd33);
      applyStimulus(1'b1, 1'b1, 64'd0, 80'd0, P_ONES, K_ONES);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput($sformatf("t3_rspValid%0d", i), 80'(rsp_valid), 80'd1);
         checkOutput($sformatf("t3_rspCt%0d", i),    80'(rsp_ct),    80'(CT_ZERO));
         checkOutput($sformatf("t3_rspId%0d", i),    80'(rsp_id),    80'd0);
         checkOutput($sformatf("t3_ready0_%0d", i),  80'(req0_ready), 80'd0);
         checkOutput($sformatf("t3_ready1_%0d", i),  80'(req1_ready), 80'd0);
         checkOutput($sformatf("t3_coreLoad%0d", i), 80'(core_load),  80'd0);
      end
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      rsp_ready = 1'b1;
      tick();
      checkOutput("t3_released", 80'(rsp_valid), 80'd0);

      // Reset in BUSY cycle 15 aborts the block; the next request still completes.
      applyStimulus(1'b0, 1'b1, 64'd0, 80'd0, P_ONES, K_ONES);
      #1;
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      repeat (15) tick();
      checkOutput("t4_busyBefore", 80'(busy), 80'd1);
      rst = 1'b1;
      tick();
      checkOutput("t4_ready0",   80'(req0_ready), 80'd0);
      checkOutput("t4_ready1",   80'(req1_ready), 80'd0);
      checkOutput("t4_rspValid", 80'(rsp_valid),  80'd0);
      checkOutput("t4_coreLoad", 80'(core_load),  80'd0);
      checkOutput("t4_rspCt",    80'(rsp_ct),     80'd0);
      checkOutput("t4_rspId",    80'(rsp_id),     80'd0);
      checkOutput("t4_busy",     80'(busy),       80'd0);
      checkOutput("t4_coreIdat", 80'(core_idat),  80'd0);
      checkOutput("t4_coreKey",  core_key,        80'd0);
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (rsp_valid || core_load) seen++;
      end
      checkOutput("t4_noResponse", 80'(seen), 80'd0);
      applyStimulus(1'b0, 1'b1, 64'd0, 80'd0, P_ONES, K_ONES);
      #1;
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      waitResp(cyc, lds);
      checkOutput("t4_latency", 80'(cyc), 80'd33);
      checkOutput("t4_rspCt",   80'(rsp_ct), 80'(CT_ONES));
      checkOutput("t4_rspId",   80'(rsp_id), 80'd1);
      tick();

`ifdef PRESENT_SCHED_WATCHDOG_EN
      // Dead core: response arrives with the error flag after 40 BUSY cycles (LOAD + 40 = 41).
      coreDead = 1'b1;
      applyStimulus(1'b1, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      #1;
      tick();
      applyStimulus(1'b0, 1'b0, 64'd0, 80'd0, 64'd0, 80'd0);
      waitResp(cyc, lds);
      checkOutput("t5_latency", 80'(cyc), 80'd41);
      checkOutput("t5_rspValid", 80'(rsp_valid), 80'd1);
      checkOutput("t5_rspErr",  80'(rsp_err), 80'd1);
      checkOutput("t5_rspCt",   80'(rsp_ct),  80'd0);
      checkOutput("t5_rspId",   80'(rsp_id),  80'd0);
      coreDead = 1'b0;
      tick();
      checkOutput("t5_released", 80'(rsp_valid), 80'd0);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
